// File: rtl/tensor_pkg.sv
// Shared sizing and state types for the tensor packer and the flat-vector stages it feeds.
package tensor_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } pack_state_t;

    function automatic int elem_count(input int ch, input int h, input int w);
        return ch * h * w;
    endfunction

endpackage

// File: rtl/tensor_bank.sv
// One N x WIDTH register bank: indexed element write, whole-bank clear, flat read-out.
module tensor_bank #(
    parameter int N     = 4,
    parameter int WIDTH = 16,
    parameter int IW    = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               we,
    input  logic [IW-1:0]      widx,
    input  logic [WIDTH-1:0]   wdata,
    output logic [N*WIDTH-1:0] rdata
);

    logic [N*WIDTH-1:0] mem_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
        end else if (clr) begin
            mem_q <= '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (we && widx == IW'(k)) mem_q[k*WIDTH +: WIDTH] <= wdata;
            end
        end
    end

    assign rdata = mem_q;

endmodule

// File: rtl/tensor_stream_packer.sv
// Packs a serial element stream into one flat CH*IN_H*IN_W tensor vector.
// Define PACKER_DBUF_EN for two alternating banks (fill and hold overlap).
//
// state | meaning
// FILL  | bank accepting elements (in_ready when it is the write bank)
// HOLD  | bank holds a complete frame, waiting for out_ready
module tensor_stream_packer
    import tensor_pkg::*;
#(
    parameter int CH    = 1,
    parameter int IN_H  = 2,
    parameter int IN_W  = 2,
    parameter int WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_data,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [CH*IN_H*IN_W*WIDTH-1:0] out_vec,
    output logic                          frame_err
);

`ifdef PACKER_DBUF_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif
    localparam int N  = elem_count(CH, IN_H, IN_W);
    localparam int IW = $clog2(N + 1);

    pack_state_t   st_q [2];
    pack_state_t   st_d [2];
    logic          wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          run_q, err_q, err_d;
    logic          acc, done, hs, at_end;
    logic [N*WIDTH-1:0] vec [2];

    // run_q keeps in_ready low while reset is asserted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q[0]  <= FILL;
            st_q[1]  <= FILL;
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
            idx_q    <= '0;
            run_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            st_q     <= st_d;
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
            idx_q    <= idx_d;
            run_q    <= 1'b1;
            err_q    <= err_d;
        end
    end

    always_comb begin
        in_ready  = run_q && (st_q[wr_sel_q] == FILL);
        out_valid = (st_q[rd_sel_q] == HOLD);
        acc       = in_valid && in_ready;
        hs        = out_valid && out_ready;
        at_end    = (idx_q == IW'(N - 1));
        done      = acc && (in_last || at_end);

        st_d     = st_q;
        wr_sel_d = wr_sel_q;
        rd_sel_d = rd_sel_q;
        idx_d    = idx_q;
        err_d    = done && (in_last != at_end);

        if (acc) idx_d = done ? '0 : idx_q + 1'b1;
        if (hs) begin
            st_d[rd_sel_q] = FILL;
            rd_sel_d       = ~rd_sel_q & (NB == 2);
        end
        if (done) begin
            st_d[wr_sel_q] = HOLD;
            wr_sel_d       = ~wr_sel_q & (NB == 2);
        end
    end

    // a bank is cleared as its frame is consumed, so early in_last leaves a zero tail
    for (genvar b = 0; b < 2; b++) begin : g_bank
        if (b < NB) begin : g_on
            tensor_bank #(.N(N), .WIDTH(WIDTH), .IW(IW)) u_bank (
                .clk   (clk),
                .rst_n (rst_n),
                .clr   (hs && (rd_sel_q == 1'(b))),
                .we    (acc && (wr_sel_q == 1'(b))),
                .widx  (idx_q),
                .wdata (in_data),
                .rdata (vec[b])
            );
        end else begin : g_off
            assign vec[b] = '0;
        end
    end

    assign out_vec   = vec[rd_sel_q];
    assign frame_err = err_q;

endmodule
